// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the integer register file
package riscv_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sequential bulk-clear engine, walks indices 1..depth-1 one per cycle
module regfile_clear_fsm
    import riscv_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    output logic                     busy_o,
    output logic                     clr_en,
    output logic [ADDRESS_WIDTH-1:0] clr_idx
);

    localparam logic [ADDRESS_WIDTH-1:0] FIRST_IDX = ADDRESS_WIDTH'(1);

    clr_state_t               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;

    // next state: start on clear_i in IDLE, step the index while clearing, stop after the last entry
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == IDLE) begin
            if (clear_i) state_d = CLEAR;
        end else begin
            idx_d = idx_q + 1'b1;
            if (idx_q == '1) begin
                state_d = IDLE;
                idx_d   = FIRST_IDX;
            end
        end
    end

    // state and index registers; entry 0 is hardwired so the walk starts at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy_o  = (state_q == CLEAR);
    assign clr_en  = busy_o;
    assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write bypass, bulk clear and debug read
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 1,
    parameter int BYPASS        = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear_i,
    output logic                              busy_o,
    input  logic [NUM_WRITE-1:0]              we_i,
    input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] waddr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]    wdata_i,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]     rdata_o,
    input  logic [ADDRESS_WIDTH-1:0]           dbg_addr_i,
    output logic [DATA_WIDTH-1:0]              dbg_data_o
);

    localparam int                       DEPTH     = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]    mem_d [DEPTH];
    logic                     clr_en;
    logic [ADDRESS_WIDTH-1:0] clr_idx;

    regfile_clear_fsm #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_clear_fsm (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(clear_i),
        .busy_o (busy_o),
        .clr_en (clr_en),
        .clr_idx(clr_idx)
    );

    // array next value: clearing owns the array; otherwise writes apply in port order so the highest port wins
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_idx] = '0;
        end else begin
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (we_i[k] && waddr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] != ZERO_ADDR)
                    mem_d[waddr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // storage array; reset zeroes every entry so nothing survives an aborted clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0]    rv;
        assign ra = raddr_i[r*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        // read mux: array, overridden by same-cycle writes, forced to 0 for x0 and while clearing
        always_comb begin
            rv = mem_q[ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WRITE; k++) begin
                    if (we_i[k] && waddr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ra)
                        rv = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (busy_o || ra == ZERO_ADDR) rv = '0;
        end
        assign rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = rv;
    end

    assign dbg_data_o = (busy_o || dbg_addr_i == ZERO_ADDR) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of regfile_mp against a behavioural model
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_i = 1'b0;
    logic [1:0]  we = '0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic [4:0]  dbg_addr = '0;
    logic [63:0] rdata1, rdata0;
    logic [31:0] dbg1, dbg0;
    logic        busy1, busy0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mm [32];
    int          clr_left;

    always #5 clk = ~clk;

    regfile_mp #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .busy_o(busy1),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata1),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg1)
    );

    regfile_mp #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .busy_o(busy0),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata0),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg0)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Model: a clear makes the whole file look zero at once, then blocks writes for 31 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mm[i] <= '0;
            clr_left <= 0;
        end else if (clr_left > 0) begin
            clr_left <= clr_left - 1;
        end else begin
            for (int k = 0; k < 2; k++)
                if (we[k] && waddr[k*5 +: 5] != 5'd0) mm[waddr[k*5 +: 5]] <= wdata[k*32 +: 32];
            if (clear_i) begin
                for (int i = 0; i < 32; i++) mm[i] <= '0;
                clr_left <= 31;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        v = mm[a];
        if (byp)
            for (int k = 0; k < 2; k++)
                if (we[k] && waddr[k*5 +: 5] == a) v = wdata[k*32 +: 32];
        if (clr_left > 0 || a == 5'd0) v = '0;
        return v;
    endfunction

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            chk("rd_bypass", rdata1[p*32 +: 32], exp_rd(raddr[p*5 +: 5], 1'b1));
            chk("rd_nobypass", rdata0[p*32 +: 32], exp_rd(raddr[p*5 +: 5], 1'b0));
        end
        chk("dbg_bypass", dbg1, exp_rd(dbg_addr, 1'b0));
        chk("dbg_nobypass", dbg0, exp_rd(dbg_addr, 1'b0));
        chk("busy_bypass", 32'(busy1), 32'(clr_left > 0));
        chk("busy_nobypass", 32'(busy0), 32'(clr_left > 0));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy1) break;
            n++;
            cyc();
            we = 2'b01;
            waddr = {5'd0, 5'd9};
            wdata = {32'd0, 32'h999};
            raddr = {5'($urandom), 5'($urandom)};
        end
        we = '0;
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            dbg_addr = 5'(a);
            @(negedge clk);
        end
        cyc();
        rst_n = 1'b1;

        cyc();
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF}; raddr = {5'd0, 5'd5};
        @(negedge clk);
        chk("x5_bypass_same", rdata1[31:0], 32'hDEADBEEF);
        chk("x5_nobypass_same", rdata0[31:0], 32'h0);
        cyc();
        we = '0;
        @(negedge clk);
        chk("x5_nobypass_next", rdata0[31:0], 32'hDEADBEEF);

        cyc();
        we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'h1234}; raddr = {5'd0, 5'd0}; dbg_addr = 5'd0;
        @(negedge clk);
        chk("x0_bypass", rdata1[31:0], 32'h0);
        cyc();
        we = '0;
        @(negedge clk);
        chk("x0_dbg", dbg1, 32'h0);
        chk("x0_read", rdata0[31:0], 32'h0);

        cyc();
        we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr = {5'd7, 5'd7};
        @(negedge clk);
        chk("x7_bypass_p0", rdata1[31:0], 32'h22);
        chk("x7_bypass_p1", rdata1[63:32], 32'h22);
        cyc();
        we = '0; dbg_addr = 5'd7;
        @(negedge clk);
        chk("x7_dbg", dbg1, 32'h22);

        for (int i = 1; i < 32; i++) begin
            cyc();
            we = 2'b01; waddr = {5'd0, 5'(i)}; wdata = {32'd0, 32'(i * 3)};
        end
        cyc();
        we = '0; dbg_addr = 5'd9; raddr = {5'd31, 5'd9};
        @(negedge clk);
        chk("fill_x9", dbg1, 32'd27);
        chk("fill_x31", rdata0[63:32], 32'd93);
        cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        count_busy(n);
        chk("clear_busy_len", 32'(n), 32'd31);
        cyc();
        dbg_addr = 5'd9;
        @(negedge clk);
        chk("x9_after_clear", dbg1, 32'h0);
        for (int a = 0; a < 32; a++) begin
            cyc();
            raddr = {5'(31 - a), 5'(a)};
            dbg_addr = 5'(a);
        end

        cyc();
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h55};
        cyc();
        we = '0; clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        repeat (9) cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk("busy_in_reset", 32'(busy1), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        count_busy(n);
        chk("restart_busy_len", 32'(n), 32'd31);

        for (int c = 0; c < 1500; c++) begin
            cyc();
            we = 2'($urandom);
            waddr = ($urandom_range(0, 3) == 0) ? {2{5'($urandom)}} : 10'($urandom);
            wdata = {$urandom, $urandom};
            raddr = ($urandom_range(0, 2) == 0) ? waddr : 10'($urandom);
            dbg_addr = 5'($urandom);
            clear_i = ($urandom_range(0, 60) == 0);
        end
        cyc();
        we = '0; clear_i = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
